ex_stage: RTL and testbench

- Execute-stage wrapper around the existing combinational ALU.
- Holds the ID/EX pipeline register and resolves operand forwarding.
- Drives alu_fn/in1/in2 into the ALU and captures its result, plus branch resolution, into the EX/MEM register.
- Sits between decode and memory stages; ALU is instantiated outside and connected through the alu_* ports.

---
 rtl/ex_stage.sv | 140 ++++++++++++++
 tb/tb_ex_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU drive
// and EX/MEM capture with branch resolution.
`ifndef FN_F
`define FN_F 0
`endif

module ex_stage #(
  parameter int BIT_WIDTH = 32,
  parameter int REG_W     = 4,
  parameter int FN_W      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [FN_W-1:0]      id_alu_fn,
  input  logic [REG_W-1:0]     id_rs1,
  input  logic [REG_W-1:0]     id_rs2,
  input  logic [BIT_WIDTH-1:0] id_rs1_data,
  input  logic [BIT_WIDTH-1:0] id_rs2_data,
  input  logic [BIT_WIDTH-1:0] id_imm,
  input  logic                 id_use_imm,
  input  logic [REG_W-1:0]     id_rd,
  input  logic                 id_wr_en,
  input  logic                 id_is_branch,
  input  logic [BIT_WIDTH-1:0] id_br_target,
  input  logic                 ex_stall,
  input  logic                 flush,
  input  logic                 mem_wr_en,
  input  logic [REG_W-1:0]     mem_rd,
  input  logic [BIT_WIDTH-1:0] mem_data,
  input  logic                 wb_wr_en,
  input  logic [REG_W-1:0]     wb_rd,
  input  logic [BIT_WIDTH-1:0] wb_data,
  output logic [FN_W-1:0]      alu_fn,
  output logic [BIT_WIDTH-1:0] alu_in1,
  output logic [BIT_WIDTH-1:0] alu_in2,
  input  logic [BIT_WIDTH-1:0] alu_out,
  output logic                 exm_valid,
  output logic [BIT_WIDTH-1:0] exm_result,
  output logic [REG_W-1:0]     exm_rd,
  output logic                 exm_wr_en,
  output logic                 br_taken,
  output logic [BIT_WIDTH-1:0] br_target
);

  typedef struct packed {
    logic                 valid;
    logic [FN_W-1:0]      fn;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic [BIT_WIDTH-1:0] rs1_data;
    logic [BIT_WIDTH-1:0] rs2_data;
    logic [BIT_WIDTH-1:0] imm;
    logic                 use_imm;
    logic [REG_W-1:0]     rd;
    logic                 wr_en;
    logic                 is_branch;
    logic [BIT_WIDTH-1:0] br_target;
  } id_ex_t;

  id_ex_t               id_ex;
  id_ex_t               id_ex_d;
  logic [BIT_WIDTH-1:0] fwd1;
  logic [BIT_WIDTH-1:0] fwd2;

  assign id_ready = !ex_stall;

  always_comb begin
    id_ex_d           = '0;
    id_ex_d.valid     = id_valid;
    id_ex_d.fn        = id_alu_fn;
    id_ex_d.rs1       = id_rs1;
    id_ex_d.rs2       = id_rs2;
    id_ex_d.rs1_data  = id_rs1_data;
    id_ex_d.rs2_data  = id_rs2_data;
    id_ex_d.imm       = id_imm;
    id_ex_d.use_imm   = id_use_imm;
    id_ex_d.rd        = id_rd;
    id_ex_d.wr_en     = id_wr_en;
    id_ex_d.is_branch = id_is_branch;
    id_ex_d.br_target = id_br_target;
  end

  // Flush wins over stall and also drops a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (reset)
      id_ex <= '0;
    else if (flush)
      id_ex.valid <= 1'b0;
    else if (!ex_stall)
      id_ex <= id_ex_d;
  end

  always_comb begin
    fwd1 = id_ex.rs1_data;
    priority case (1'b1)
      exm_valid && exm_wr_en
        && exm_rd == id_ex.rs1:          fwd1 = exm_result;
      mem_wr_en && mem_rd == id_ex.rs1: fwd1 = mem_data;
      wb_wr_en && wb_rd == id_ex.rs1:   fwd1 = wb_data;
      default:                          fwd1 = id_ex.rs1_data;
    endcase
  end

  always_comb begin
    fwd2 = id_ex.rs2_data;
    priority case (1'b1)
      exm_valid && exm_wr_en
        && exm_rd == id_ex.rs2:          fwd2 = exm_result;
      mem_wr_en && mem_rd == id_ex.rs2: fwd2 = mem_data;
      wb_wr_en && wb_rd == id_ex.rs2:   fwd2 = wb_data;
      default:                          fwd2 = id_ex.rs2_data;
    endcase
  end

  assign alu_in1 = fwd1;
  assign alu_in2 = id_ex.use_imm ? id_ex.imm : fwd2;
  assign alu_fn  = id_ex.valid ? id_ex.fn : FN_W'(`FN_F);

  // EX/MEM ignores flush so the redirecting branch still retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      exm_valid  <= 1'b0;
      exm_result <= '0;
      exm_rd     <= '0;
      exm_wr_en  <= 1'b0;
      br_taken   <= 1'b0;
      br_target  <= '0;
    end else if (!ex_stall) begin
      exm_valid  <= id_ex.valid;
      exm_result <= alu_out;
      exm_rd     <= id_ex.rd;
      exm_wr_en  <= id_ex.wr_en && id_ex.valid;
      br_taken   <= id_ex.valid && id_ex.is_branch && alu_out[0];
      br_target  <= id_ex.br_target;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage with a stub ALU and
// an instruction-level reference model.
`ifndef FN_F
`define FN_F 0
`endif

module tb_ex_stage;
  localparam int W  = 32;
  localparam int RW = 4;
  localparam int FW = 5;
  localparam logic [4:0] F_ADD = 5'd1;
  localparam logic [4:0] F_SUB = 5'd2;
  localparam logic [4:0] F_EQ  = 5'd3;
  localparam logic [4:0] F_XOR = 5'd4;
  localparam logic [4:0] F_NOP = 5'(`FN_F);

  logic clk, reset;
  logic id_valid, id_ready;
  logic [FW-1:0] id_alu_fn;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic [W-1:0] id_rs1_data, id_rs2_data, id_imm, id_br_target;
  logic id_use_imm, id_wr_en, id_is_branch;
  logic ex_stall, flush;
  logic mem_wr_en, wb_wr_en;
  logic [RW-1:0] mem_rd, wb_rd;
  logic [W-1:0] mem_data, wb_data;
  logic [FW-1:0] alu_fn;
  logic [W-1:0] alu_in1, alu_in2, alu_out;
  logic exm_valid, exm_wr_en, br_taken;
  logic [W-1:0] exm_result, br_target;
  logic [RW-1:0] exm_rd;

  ex_stage #(.BIT_WIDTH(W), .REG_W(RW), .FN_W(FW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_alu_fn(id_alu_fn),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_branch(id_is_branch), .id_br_target(id_br_target),
    .ex_stall(ex_stall), .flush(flush),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_fn(alu_fn), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out),
    .exm_valid(exm_valid), .exm_result(exm_result),
    .exm_rd(exm_rd), .exm_wr_en(exm_wr_en),
    .br_taken(br_taken), .br_target(br_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(
    input logic [4:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    case (fn)
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      F_EQ:    return (a == b) ? 32'd1 : 32'd0;
      F_XOR:   return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_fn, alu_in1, alu_in2);

  typedef struct {
    logic v; logic [4:0] fn; logic [3:0] rs1, rs2;
    logic [W-1:0] d1, d2, imm; logic ui; logic [3:0] rd;
    logic wr, br; logic [W-1:0] tgt;
  } ins_t;
  typedef struct {
    logic [W-1:0] res; logic [3:0] rd; logic wr, tk; logic [W-1:0] tgt;
  } exp_t;

  ins_t m_ex;
  logic mx_v, mx_wr;
  logic [W-1:0] mx_res;
  logic [3:0] mx_rd;
  exp_t q[$];
  bit upd;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Value an instruction should see for a source register right now.
  function automatic logic [W-1:0] src(input logic [3:0] rs,
                                       input logic [W-1:0] d);
    if (mx_v && mx_wr && mx_rd == rs) return mx_res;
    if (mem_wr_en && mem_rd == rs) return mem_data;
    if (wb_wr_en && wb_rd == rs) return wb_data;
    return d;
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] a, b, r;
    if (reset) begin
      m_ex.v = 1'b0; mx_v = 1'b0; mx_wr = 1'b0;
      mx_res = '0; mx_rd = '0; upd = 1'b0;
    end else begin
      upd = !ex_stall;
      if (!ex_stall) begin
        if (m_ex.v) begin
          a = src(m_ex.rs1, m_ex.d1);
          b = m_ex.ui ? m_ex.imm : src(m_ex.rs2, m_ex.d2);
          r = alu_f(m_ex.fn, a, b);
          q.push_back('{r, m_ex.rd, m_ex.wr, m_ex.br && r[0], m_ex.tgt});
          mx_v = 1'b1; mx_res = r; mx_rd = m_ex.rd; mx_wr = m_ex.wr;
        end else begin
          mx_v = 1'b0; mx_wr = 1'b0;
        end
      end
      if (flush) m_ex.v = 1'b0;
      else if (!ex_stall)
        m_ex = '{id_valid, id_alu_fn, id_rs1, id_rs2, id_rs1_data,
                 id_rs2_data, id_imm, id_use_imm, id_rd, id_wr_en,
                 id_is_branch, id_br_target};
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("id_ready", {31'b0, id_ready}, {31'b0, !ex_stall});
      chk("exm_valid", {31'b0, exm_valid}, {31'b0, mx_v});
      chk("alu_fn", {27'b0, alu_fn}, {27'b0, m_ex.v ? m_ex.fn : F_NOP});
      if (m_ex.v) begin
        chk("alu_in1", alu_in1, src(m_ex.rs1, m_ex.d1));
        chk("alu_in2", alu_in2,
            m_ex.ui ? m_ex.imm : src(m_ex.rs2, m_ex.d2));
      end
      if (upd && exm_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow: unexpected retire at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("sb_result", exm_result, e.res);
          chk("sb_rd", {28'b0, exm_rd}, {28'b0, e.rd});
          chk("sb_wr_en", {31'b0, exm_wr_en}, {31'b0, e.wr});
          chk("sb_br_taken", {31'b0, br_taken}, {31'b0, e.tk});
          if (e.tk) chk("sb_br_target", br_target, e.tgt);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ins(input logic v, input logic [4:0] fn,
      input logic [3:0] rs1, input logic [3:0] rs2,
      input logic [W-1:0] d1, input logic [W-1:0] d2,
      input logic [W-1:0] imm, input logic ui, input logic [3:0] rd,
      input logic wr, input logic br, input logic [W-1:0] tgt);
    id_valid = v; id_alu_fn = fn; id_rs1 = rs1; id_rs2 = rs2;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_use_imm = ui; id_rd = rd; id_wr_en = wr;
    id_is_branch = br; id_br_target = tgt;
  endtask

  task automatic no_fwd();
    mem_wr_en = 0; mem_rd = 0; mem_data = 0;
    wb_wr_en = 0; wb_rd = 0; wb_data = 0;
  endtask

  logic [4:0] fns [4];
  int k;

  initial begin
    fns = '{F_ADD, F_SUB, F_EQ, F_XOR};
    reset = 1; ex_stall = 0; flush = 0;
    no_fwd();
    set_ins(1, F_ADD, 0, 0, 1, 2, 3, 1, 5, 1, 1, 32'h10);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_exm_valid", {31'b0, exm_valid}, 0);
      chk("rst_br_taken", {31'b0, br_taken}, 0);
      chk("rst_exm_result", exm_result, 0);
    end
    step();
    reset = 0;
    set_ins(0, F_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    set_ins(1, F_ADD, 0, 0, 0, 0, 5, 1, 1, 1, 0, 0);
    step();
    @(negedge clk);
    chk("first_not_early", {31'b0, exm_valid}, 0);
    #1;
    set_ins(1, F_ADD, 1, 1, 99, 77, 0, 0, 2, 1, 0, 0);
    step();
    @(negedge clk);
    chk("first_retire", {31'b0, exm_valid}, 1);
    chk("dep_in1", alu_in1, 5);
    chk("dep_in2", alu_in2, 5);
    #1 id_valid = 0;
    step();
    @(negedge clk);
    chk("dep_result", exm_result, 10);
    #1;

    set_ins(1, F_ADD, 3, 0, 1, 0, 0, 1, 4, 1, 0, 0);
    mem_wr_en = 1; mem_rd = 3; mem_data = 7;
    wb_wr_en = 1; wb_rd = 3; wb_data = 9;
    step();
    id_valid = 0;
    @(negedge clk);
    chk("mem_beats_wb", alu_in1, 7);
    #1 mem_wr_en = 0;
    #1 chk("wb_only", alu_in1, 9);
    step();
    @(negedge clk);
    chk("wb_result", exm_result, 9);
    #1 no_fwd();

    set_ins(1, F_EQ, 5, 6, 4, 4, 0, 0, 0, 0, 1, 32'h40);
    step();
    set_ins(1, F_EQ, 5, 6, 4, 5, 0, 0, 0, 0, 1, 32'h80);
    step();
    @(negedge clk);
    chk("br_taken_eq", {31'b0, br_taken}, 1);
    chk("br_target_eq", br_target, 32'h40);
    #1 id_valid = 0;
    step();
    @(negedge clk);
    chk("br_not_taken", {31'b0, br_taken}, 0);
    #1;

    k = 0;
    for (int i = 0; i < 10; i++) begin
      ex_stall = (i >= 2 && i < 5);
      set_ins(k < 6, F_ADD, 0, 0, 0, 0, 32'(100 + k), 1, 7, 1, 0, 0);
      if (!ex_stall) k++;
      step();
      if (ex_stall) chk("stall_ready", {31'b0, id_ready}, 0);
    end
    ex_stall = 0; id_valid = 0;
    step();

    set_ins(1, F_EQ, 5, 6, 4, 4, 0, 0, 0, 0, 1, 32'h44);
    step();
    id_valid = 0;
    step();
    flush = 1; ex_stall = 1;
    set_ins(1, F_ADD, 1, 2, 3, 4, 0, 0, 3, 1, 0, 0);
    step();
    @(negedge clk);
    chk("flush_idex", {27'b0, alu_fn}, {27'b0, F_NOP});
    chk("flush_br_kept", {31'b0, br_taken}, 1);
    chk("flush_tgt_kept", br_target, 32'h44);
    #1 flush = 0; ex_stall = 0; id_valid = 0;
    step();

    for (int i = 0; i < 400; i++) begin
      set_ins($urandom_range(0, 3) != 0, fns[$urandom_range(0, 3)],
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom,
              $urandom_range(0, 3) == 0, 4'($urandom_range(0, 3)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom);
      ex_stall = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 9) == 0;
      mem_wr_en = $urandom_range(0, 1);
      mem_rd = 4'($urandom_range(0, 3));
      mem_data = $urandom;
      wb_wr_en = $urandom_range(0, 1);
      wb_rd = 4'($urandom_range(0, 3));
      wb_data = $urandom;
      step();
    end

    id_valid = 0; ex_stall = 0; flush = 0;
    repeat (4) step();
    chk("sb_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
